// File: rtl/posicao_robo.sv
// posicao_robo: tracks a robot's cell on a GRID_W x GRID_H grid, applies
// single-cell moves, flags moves refused at the grid edge, counts executed
// steps and latches arrival at the target cell until released.
// Optional feature: define POSICAO_WRAP_EN to make edge moves wrap around
// instead of being refused.
module posicao_robo #(
  parameter int GRID_W = 10,
  parameter int GRID_H = 10,
  parameter int X0     = 0,
  parameter int Y0     = 0
) (
  input  logic       c3,
  input  logic       reset,
  input  logic [2:0] acao,
  input  logic [3:0] alvo_x,
  input  logic [3:0] alvo_y,
  input  logic       liberar,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic       colisao,
  output logic [7:0] passos,
  output logic       chegou,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MOVE = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [3:0] XMAX   = 4'(GRID_W - 1);
  localparam logic [3:0] YMAX   = 4'(GRID_H - 1);
  localparam logic [3:0] XSTART = 4'(X0);
  localparam logic [3:0] YSTART = 4'(Y0);

`ifdef POSICAO_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  state_t     state;
  logic       isDir;
  logic       edgeHit;
  logic       refused;
  logic [3:0] nextX;
  logic [3:0] nextY;

  assign estado  = state;
  assign refused = edgeHit & ~WRAP;

  // Decode the movement code into a candidate cell, noting when it crosses an edge
  always_comb begin
    isDir   = 1'b0;
    edgeHit = 1'b0;
    nextX   = pos_x;
    nextY   = pos_y;
    case (acao)
      3'b001: begin
        isDir = 1'b1;
        if (pos_y == YMAX) begin
          edgeHit = 1'b1;
          nextY   = 4'd0;
        end else begin
          nextY = pos_y + 4'd1;
        end
      end
      3'b100: begin
        isDir = 1'b1;
        if (pos_y == 4'd0) begin
          edgeHit = 1'b1;
          nextY   = YMAX;
        end else begin
          nextY = pos_y - 4'd1;
        end
      end
      3'b011: begin
        isDir = 1'b1;
        if (pos_x == XMAX) begin
          edgeHit = 1'b1;
          nextX   = 4'd0;
        end else begin
          nextX = pos_x + 4'd1;
        end
      end
      3'b010: begin
        isDir = 1'b1;
        if (pos_x == 4'd0) begin
          edgeHit = 1'b1;
          nextX   = XMAX;
        end else begin
          nextX = pos_x - 4'd1;
        end
      end
      default: begin
        isDir = 1'b0;
      end
    endcase
  end

  // State machine with registered position, step counter and status flags
  always_ff @(posedge c3) begin
    if (!reset) begin
      state   <= IDLE;
      pos_x   <= XSTART;
      pos_y   <= YSTART;
      passos  <= 8'd0;
      colisao <= 1'b0;
      chegou  <= 1'b0;
    end else begin
      colisao <= 1'b0;
      case (state)
        DONE: begin
          if (liberar) begin
            state  <= IDLE;
            chegou <= 1'b0;
          end
        end
        default: begin
          if (!isDir) begin
            state <= IDLE;
          end else if (refused) begin
            colisao <= 1'b1;
            state   <= MOVE;
          end else begin
            pos_x  <= nextX;
            pos_y  <= nextY;
            passos <= (passos == 8'hFF) ? passos : passos + 8'd1;
            if (nextX == alvo_x && nextY == alvo_y) begin
              state  <= DONE;
              chegou <= 1'b1;
            end else begin
              state <= MOVE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posicao_robo.sv
// tb_posicao_robo: directed self-checking bench for posicao_robo on the
// default 10x10 grid starting at (0,0). Edge expectations follow the
// POSICAO_WRAP_EN setting of the build.
module tb_posicao_robo;

  logic       c3;
  logic       reset;
  logic [2:0] acao;
  logic [3:0] alvoX;
  logic [3:0] alvoY;
  logic       liberar;
  logic [3:0] posX;
  logic [3:0] posY;
  logic       colisao;
  logic [7:0] passos;
  logic       chegou;
  logic [1:0] estado;

  int testsRun  = 0;
  int failCount = 0;
  logic sawColl;

  posicao_robo #(
    .GRID_W(10),
    .GRID_H(10),
    .X0(0),
    .Y0(0)
  ) dut (
    .c3(c3),
    .reset(reset),
    .acao(acao),
    .alvo_x(alvoX),
    .alvo_y(alvoY),
    .liberar(liberar),
    .pos_x(posX),
    .pos_y(posY),
    .colisao(colisao),
    .passos(passos),
    .chegou(chegou),
    .estado(estado)
  );

  // Free-running clock, 10 time units per period
  initial c3 = 1'b0;
  always #5 c3 = ~c3;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one movement code across one rising edge, then settle past it
  task automatic applyStimulus(input logic [2:0] code);
    acao = code;
    @(posedge c3);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    @(posedge c3);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    acao    = 3'b000;
    alvoX   = 4'd15;
    alvoY   = 4'd15;
    liberar = 1'b0;
    #2;
    applyReset();

    // Reset state
    checkOutput("rst_posx", posX, 0);
    checkOutput("rst_posy", posY, 0);
    checkOutput("rst_passos", passos, 0);
    checkOutput("rst_colisao", colisao, 0);
    checkOutput("rst_chegou", chegou, 0);
    checkOutput("rst_estado", estado, 2'b00);

    // Three steps east; liberar held high outside DONE must not matter
    sawColl = 1'b0;
    liberar = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b011);
      sawColl = sawColl | colisao;
    end
    liberar = 1'b0;
    checkOutput("east3_posx", posX, 3);
    checkOutput("east3_posy", posY, 0);
    checkOutput("east3_passos", passos, 3);
    checkOutput("east3_estado", estado, 2'b01);
    checkOutput("east3_nocoll", sawColl, 0);

    // Invalid code: no motion, back to IDLE
    applyStimulus(3'b111);
    checkOutput("inv_posx", posX, 3);
    checkOutput("inv_passos", passos, 3);
    checkOutput("inv_estado", estado, 2'b00);

    // West twice from the origin
    applyReset();
    applyStimulus(3'b010);
`ifdef POSICAO_WRAP_EN
    checkOutput("west1_colisao", colisao, 0);
    checkOutput("west1_posx", posX, 9);
`else
    checkOutput("west1_colisao", colisao, 1);
    checkOutput("west1_posx", posX, 0);
`endif
    applyStimulus(3'b010);
`ifdef POSICAO_WRAP_EN
    checkOutput("west2_colisao", colisao, 0);
    checkOutput("west2_posx", posX, 8);
    checkOutput("west2_passos", passos, 2);
`else
    checkOutput("west2_colisao", colisao, 1);
    checkOutput("west2_posx", posX, 0);
    checkOutput("west2_passos", passos, 0);
`endif
    checkOutput("west2_estado", estado, 2'b01);
    applyStimulus(3'b000);
    checkOutput("west_stop_colisao", colisao, 0);
    checkOutput("west_stop_estado", estado, 2'b00);

    // North to target (0,2), then hold in DONE and release
    applyReset();
    alvoX = 4'd0;
    alvoY = 4'd2;
    applyStimulus(3'b001);
    checkOutput("n1_posy", posY, 1);
    checkOutput("n1_chegou", chegou, 0);
    applyStimulus(3'b001);
    checkOutput("n2_posy", posY, 2);
    checkOutput("n2_chegou", chegou, 1);
    checkOutput("n2_estado", estado, 2'b10);
    alvoY = 4'd5;
    applyStimulus(3'b001);
    applyStimulus(3'b011);
    checkOutput("done_posx", posX, 0);
    checkOutput("done_posy", posY, 2);
    checkOutput("done_passos", passos, 2);
    checkOutput("done_chegou", chegou, 1);
    checkOutput("done_colisao", colisao, 0);
    liberar = 1'b1;
    applyStimulus(3'b001);
    liberar = 1'b0;
    checkOutput("rel_estado", estado, 2'b00);
    checkOutput("rel_chegou", chegou, 0);
    checkOutput("rel_posy", posY, 2);
    checkOutput("rel_passos", passos, 2);

    // Target equals start: idling does not arrive, stepping back does
    applyReset();
    alvoX = 4'd0;
    alvoY = 4'd0;
    for (int i = 0; i < 5; i++) applyStimulus(3'b000);
    checkOutput("idle_chegou", chegou, 0);
    checkOutput("idle_estado", estado, 2'b00);
    applyStimulus(3'b001);
    checkOutput("out_chegou", chegou, 0);
    applyStimulus(3'b100);
    checkOutput("back_posy", posY, 0);
    checkOutput("back_chegou", chegou, 1);
    checkOutput("back_passos", passos, 2);

    // Reach (4,4), then reset coinciding with a step
    applyReset();
    alvoX = 4'd15;
    alvoY = 4'd15;
    for (int i = 0; i < 4; i++) applyStimulus(3'b011);
    for (int i = 0; i < 4; i++) applyStimulus(3'b001);
    checkOutput("at44_posx", posX, 4);
    checkOutput("at44_posy", posY, 4);
    checkOutput("at44_passos", passos, 8);
    reset = 1'b0;
    applyStimulus(3'b001);
    checkOutput("rstmv_posx", posX, 0);
    checkOutput("rstmv_posy", posY, 0);
    checkOutput("rstmv_passos", passos, 0);
    checkOutput("rstmv_estado", estado, 2'b00);
    reset = 1'b1;
    applyStimulus(3'b001);
    checkOutput("post_rst_posy", posY, 1);
    checkOutput("post_rst_passos", passos, 1);

    // North edge: two consecutive attempts past y=9
    applyReset();
    for (int i = 0; i < 9; i++) applyStimulus(3'b001);
    checkOutput("top_posy", posY, 9);
    applyStimulus(3'b001);
`ifdef POSICAO_WRAP_EN
    checkOutput("top1_colisao", colisao, 0);
    checkOutput("top1_posy", posY, 0);
    checkOutput("top1_passos", passos, 10);
`else
    checkOutput("top1_colisao", colisao, 1);
    checkOutput("top1_posy", posY, 9);
    checkOutput("top1_passos", passos, 9);
`endif
    applyStimulus(3'b001);
`ifdef POSICAO_WRAP_EN
    checkOutput("top2_colisao", colisao, 0);
    checkOutput("top2_posy", posY, 1);
`else
    checkOutput("top2_colisao", colisao, 1);
    checkOutput("top2_posy", posY, 9);
`endif

    // Saturate the step counter by shuttling east/west
    applyReset();
    for (int i = 0; i < 255; i++) applyStimulus((i % 2 == 0) ? 3'b011 : 3'b010);
    checkOutput("sat_passos", passos, 255);
    checkOutput("sat_posx", posX, 1);
    applyStimulus(3'b011);
    checkOutput("sat_hold_passos", passos, 255);
    checkOutput("sat_hold_posx", posX, 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
